// File: rtl/cache_pkg.sv
// Shared constants for the L2 cache: opcodes, FSM states, valid and hit encodings.
package cache_pkg;

   localparam logic [1:0] OP_FLASH      = 2'b00;
   localparam logic [1:0] OP_READ       = 2'b01;
   localparam logic [1:0] OP_WRITE      = 2'b10;
   localparam logic [1:0] OP_INVALIDATE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic VALID_SET = 1'b1;
   localparam logic VALID_CLR = 1'b0;

   // Hit/miss encoding shared with the L1 cache.
   localparam logic HIT  = 1'b1;
   localparam logic MISS = 1'b0;

endpackage

// File: rtl/cache_l2_lru_if.sv
// Request/response bundle between an L1-side requester and the L2 cache.
interface cache_l2_lru_if #(
   parameter int unsigned TAG_WIDTH    = 4,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned OPCODE_WIDTH = 2
) ();

   localparam int unsigned LINE_WIDTH = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH;

   logic [LINE_WIDTH-1:0] vector_in;
   logic                  req_valid;
   logic                  req_ready;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  hit_miss_out;
   logic                  evict_out;
   logic [TAG_WIDTH-1:0]  evict_tag_out;
   logic [DATA_WIDTH-1:0] evict_data_out;

   modport master (
      output vector_in, req_valid, resp_ready,
      input  req_ready, resp_valid, data_out, hit_miss_out,
             evict_out, evict_tag_out, evict_data_out
   );

   modport slave (
      input  vector_in, req_valid, resp_ready,
      output req_ready, resp_valid, data_out, hit_miss_out,
             evict_out, evict_tag_out, evict_data_out
   );

endinterface

// File: rtl/lru_age_tracker.sv
// True-LRU age array: age 0 is MRU, ages always form a permutation of 0..ENTRIES-1.
module lru_age_tracker #(
   parameter  int unsigned ENTRIES    = 16,
   localparam int unsigned ENTRY_BITS = $clog2(ENTRIES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  touch,
   input  logic [ENTRY_BITS-1:0] touch_idx,
   output logic [ENTRY_BITS-1:0] lru_idx
);

   logic [ENTRY_BITS-1:0] age_q [ENTRIES];
   logic [ENTRY_BITS-1:0] touch_age;

   assign touch_age = age_q[touch_idx];

   // Touched entry becomes MRU; every entry younger than it ages by one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            age_q[i] <= ENTRY_BITS'(i);
         end
      end else if (touch) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (ENTRY_BITS'(i) == touch_idx) begin
               age_q[i] <= '0;
            end else if (age_q[i] < touch_age) begin
               age_q[i] <= age_q[i] + ENTRY_BITS'(1);
            end
         end
      end
   end

   // Locate the oldest entry.
   always_comb begin
      lru_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (age_q[i] == ENTRY_BITS'(ENTRIES - 1)) begin
            lru_idx = ENTRY_BITS'(i);
         end
      end
   end

endmodule

// File: rtl/cache_l2_lru.sv
// Clocked fully-associative L2 cache with valid/ready handshake, true-LRU
// replacement, invalidate and eviction reporting.
module cache_l2_lru
   import cache_pkg::*;
#(
   parameter  int unsigned TAG_WIDTH    = 4,
   parameter  int unsigned DATA_WIDTH   = 8,
   parameter  int unsigned ENTRIES      = 16,
   parameter  int unsigned OPCODE_WIDTH = 2,
   localparam int unsigned LINE_WIDTH   = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH,
   localparam int unsigned ENTRY_BITS   = $clog2(ENTRIES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   cache_l2_lru_if.slave bus
);

   state_t state_q, state_d;
   logic   do_lookup;

   logic [LINE_WIDTH-1:0]   req_q;
   logic [OPCODE_WIDTH-1:0] req_op;
   logic [TAG_WIDTH-1:0]    req_tag;
   logic [DATA_WIDTH-1:0]   req_data;

   logic [ENTRIES-1:0]    valid_q, valid_d;
   logic [TAG_WIDTH-1:0]  tag_q  [ENTRIES];
   logic [DATA_WIDTH-1:0] data_q [ENTRIES];

   logic                  hit;
   logic                  has_free;
   logic [ENTRY_BITS-1:0] hit_idx, free_idx, victim_idx, lru_idx;

   logic                  wr_en, touch;
   logic [ENTRY_BITS-1:0] wr_idx, touch_idx;

   logic                  rsp_hit_d, rsp_hit_q;
   logic                  rsp_evict_d, rsp_evict_q;
   logic [DATA_WIDTH-1:0] rsp_data_d, rsp_data_q;
   logic [TAG_WIDTH-1:0]  rsp_etag_d, rsp_etag_q;
   logic [DATA_WIDTH-1:0] rsp_edata_d, rsp_edata_q;

   assign req_op   = req_q[LINE_WIDTH-1 -: OPCODE_WIDTH];
   assign req_tag  = req_q[DATA_WIDTH +: TAG_WIDTH];
   assign req_data = req_q[DATA_WIDTH-1:0];

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_d        = state_q;
      do_lookup      = 1'b0;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.req_ready = enable;
            if (bus.req_valid && enable) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            do_lookup = 1'b1;
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request capture at acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q <= '0;
      end else if (state_q == ST_IDLE && bus.req_valid && enable) begin
         req_q <= bus.vector_in;
      end
   end

   // Tag match, lowest free entry and replacement victim.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      has_free = 1'b0;
      free_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (!hit && valid_q[i] == VALID_SET && tag_q[i] == req_tag) begin
            hit     = 1'b1;
            hit_idx = ENTRY_BITS'(i);
         end
         if (!has_free && valid_q[i] == VALID_CLR) begin
            has_free = 1'b1;
            free_idx = ENTRY_BITS'(i);
         end
      end
      victim_idx = has_free ? free_idx : lru_idx;
   end

   // Opcode decode: array update, LRU touch and response values.
   always_comb begin
      valid_d     = valid_q;
      wr_en       = 1'b0;
      wr_idx      = hit_idx;
      touch       = 1'b0;
      touch_idx   = hit_idx;
      rsp_hit_d   = MISS;
      rsp_data_d  = '0;
      rsp_evict_d = 1'b0;
      rsp_etag_d  = '0;
      rsp_edata_d = '0;
      case (req_op)
         OP_FLASH: begin
            valid_d = {ENTRIES{VALID_CLR}};
         end
         OP_READ: begin
            if (hit) begin
               rsp_hit_d  = HIT;
               rsp_data_d = data_q[hit_idx];
               touch      = 1'b1;
            end
         end
         OP_WRITE: begin
            wr_en = 1'b1;
            touch = 1'b1;
            if (hit) begin
               rsp_hit_d = HIT;
            end else begin
               wr_idx              = victim_idx;
               valid_d[victim_idx] = VALID_SET;
               if (valid_q[victim_idx] == VALID_SET) begin
                  rsp_evict_d = 1'b1;
                  rsp_etag_d  = tag_q[victim_idx];
                  rsp_edata_d = data_q[victim_idx];
               end
            end
            touch_idx = wr_idx;
         end
         OP_INVALIDATE: begin
            if (hit) begin
               rsp_hit_d        = HIT;
               valid_d[hit_idx] = VALID_CLR;
            end
         end
         default: ;
      endcase
   end

   // Valid bits: cleared by reset, updated only on the lookup edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         valid_q <= {ENTRIES{VALID_CLR}};
      else if (do_lookup) valid_q <= valid_d;
   end

   // Tag/data storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (do_lookup && wr_en) begin
         tag_q[wr_idx]  <= req_tag;
         data_q[wr_idx] <= req_data;
      end
   end

   // Response registers, loaded on the lookup edge and held through RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_hit_q   <= MISS;
         rsp_data_q  <= '0;
         rsp_evict_q <= 1'b0;
         rsp_etag_q  <= '0;
         rsp_edata_q <= '0;
      end else if (do_lookup) begin
         rsp_hit_q   <= rsp_hit_d;
         rsp_data_q  <= rsp_data_d;
         rsp_evict_q <= rsp_evict_d;
         rsp_etag_q  <= rsp_etag_d;
         rsp_edata_q <= rsp_edata_d;
      end
   end

   assign bus.hit_miss_out   = rsp_hit_q;
   assign bus.data_out       = rsp_data_q;
   assign bus.evict_out      = rsp_evict_q;
   assign bus.evict_tag_out  = rsp_etag_q;
   assign bus.evict_data_out = rsp_edata_q;

   lru_age_tracker #(.ENTRIES(ENTRIES)) u_lru (
      .clk       (clk),
      .reset     (reset),
      .touch     (do_lookup && touch),
      .touch_idx (touch_idx),
      .lru_idx   (lru_idx)
   );

endmodule

// File: tb/tb_cache_l2_lru.sv
// Randomized and directed checks of cache_l2_lru against a queue-based LRU model.
module tb_cache_l2_lru;

   localparam int unsigned TW = 5;
   localparam int unsigned DW = 8;
   localparam int unsigned NE = 16;
   localparam int unsigned LW = 2 + TW + DW;

   logic clk    = 1'b0;
   logic reset  = 1'b0;
   logic enable = 1'b1;

   always #5 clk = ~clk;

   cache_l2_lru_if #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .OPCODE_WIDTH(2)) bus ();

   cache_l2_lru #(
      .TAG_WIDTH(TW), .DATA_WIDTH(DW), .ENTRIES(NE), .OPCODE_WIDTH(2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: per-entry contents plus an LRU order list (front = MRU).
   bit m_valid [NE];
   int m_tag   [NE];
   int m_data  [NE];
   int lru_q   [$];

   int exp_hit, exp_data, exp_ev, exp_etag, exp_edata;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic model_reset();
      lru_q = {};
      for (int i = 0; i < NE; i++) begin
         m_valid[i] = 1'b0;
         lru_q.push_back(i);
      end
   endtask

   task automatic model_touch(input int e);
      for (int k = 0; k < lru_q.size(); k++) begin
         if (lru_q[k] == e) begin
            lru_q.delete(k);
            break;
         end
      end
      lru_q.push_front(e);
   endtask

   task automatic model_op(input int op, input int tag, input int data);
      int h;
      int v;
      h = -1;
      for (int i = 0; i < NE; i++) if (m_valid[i] && m_tag[i] == tag) h = i;
      exp_hit = 0; exp_data = 0; exp_ev = 0; exp_etag = 0; exp_edata = 0;
      case (op)
         0: for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
         1: if (h >= 0) begin
               exp_hit  = 1;
               exp_data = m_data[h];
               model_touch(h);
            end
         2: if (h >= 0) begin
               exp_hit   = 1;
               m_data[h] = data;
               model_touch(h);
            end else begin
               v = -1;
               for (int i = 0; i < NE; i++) if (!m_valid[i] && v < 0) v = i;
               if (v < 0) begin
                  v         = lru_q[$];
                  exp_ev    = 1;
                  exp_etag  = m_tag[v];
                  exp_edata = m_data[v];
               end
               m_valid[v] = 1'b1;
               m_tag[v]   = tag;
               m_data[v]  = data;
               model_touch(v);
            end
         default: if (h >= 0) begin
               exp_hit    = 1;
               m_valid[h] = 1'b0;
            end
      endcase
   endtask

   // Present a request, wait for acceptance, then walk LOOKUP into RESP.
   task automatic send(input int op, input int tag, input int data, input bit drop_en);
      int n;
      bus.vector_in = {2'(op), TW'(tag), DW'(data)};
      bus.req_valid = 1'b1;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) chk("accept_timeout", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.vector_in = LW'($urandom);
      if (drop_en) enable = 1'b0;
      @(negedge clk);
      chk("lat_lookup", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      chk("lat_resp", 32'(bus.resp_valid), 32'd1);
   endtask

   task automatic check_resp();
      chk("data_out", 32'(bus.data_out), 32'(exp_data));
      chk("hit", 32'(bus.hit_miss_out), 32'(exp_hit));
      chk("evict", 32'(bus.evict_out), 32'(exp_ev));
      chk("evict_tag", 32'(bus.evict_tag_out), 32'(exp_etag));
      chk("evict_data", 32'(bus.evict_data_out), 32'(exp_edata));
   endtask

   task automatic release_resp(input int stall);
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         chk("stall_valid", 32'(bus.resp_valid), 32'd1);
         chk("stall_data", 32'(bus.data_out), 32'(exp_data));
         chk("stall_hit", 32'(bus.hit_miss_out), 32'(exp_hit));
         chk("stall_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      @(negedge clk);
      chk("idle_valid", 32'(bus.resp_valid), 32'd0);
   endtask

   task automatic do_op(input int op, input int tag, input int data, input int stall);
      send(op, tag, data, 1'b0);
      model_op(op, tag, data);
      check_resp();
      release_resp(stall);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.vector_in  = '0;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);

      // Reset values; req_ready tracks enable even in reset.
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_data", 32'(bus.data_out), 32'd0);
      chk("rst_hit", 32'(bus.hit_miss_out), 32'd0);
      chk("rst_evict", 32'(bus.evict_out), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      enable = 1'b0;
      #1;
      chk("rst_req_ready_en0", 32'(bus.req_ready), 32'd0);
      enable = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Cold miss, then write and read back.
      do_op(1, 9, 0, 0);
      do_op(2, 9, 8'hB2, 0);
      send(1, 9, 0, 1'b0);
      model_op(1, 9, 0);
      check_resp();
      chk("plan_read_b2", 32'(bus.data_out), 32'hB2);
      release_resp(0);

      // Full array, tag 0 refreshed, so tag 1 is the victim.
      do_op(0, 0, 0, 0);
      for (int t = 0; t < 16; t++) do_op(2, t, t, 0);
      do_op(1, 0, 0, 0);
      send(2, 16, 8'h16, 1'b0);
      model_op(2, 16, 8'h16);
      check_resp();
      chk("plan_evict", 32'(bus.evict_out), 32'd1);
      chk("plan_evict_tag", 32'(bus.evict_tag_out), 32'd1);
      chk("plan_evict_data", 32'(bus.evict_data_out), 32'd1);
      release_resp(0);

      // Invalidate frees entry 3 for the next write miss.
      do_op(3, 3, 0, 0);
      do_op(1, 3, 0, 0);
      send(2, 20, 8'h77, 1'b0);
      model_op(2, 20, 8'h77);
      check_resp();
      chk("plan_no_evict", 32'(bus.evict_out), 32'd0);
      release_resp(0);
      do_op(3, 25, 0, 0);

      // Response held under backpressure.
      do_op(1, 20, 0, 5);

      // Reset pulse while in RESP abandons the response and clears valids.
      send(1, 20, 0, 1'b0);
      model_op(1, 20, 0);
      check_resp();
      #1 reset = 1'b0;
      #1;
      chk("rstp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rstp_data", 32'(bus.data_out), 32'd0);
      chk("rstp_hit", 32'(bus.hit_miss_out), 32'd0);
      chk("rstp_evict", 32'(bus.evict_out), 32'd0);
      chk("rstp_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      do_op(1, 20, 0, 0);
      do_op(1, 9, 0, 0);

      // FLASH after four writes.
      for (int t = 1; t <= 4; t++) do_op(2, t, 8'h40 + t, 0);
      do_op(0, 0, 0, 0);
      for (int t = 1; t <= 4; t++) do_op(1, t, 0, 0);

      // Enable drop during LOOKUP: operation completes, acceptance blocked after.
      do_op(2, 7, 8'hC3, 0);
      send(1, 7, 0, 1'b1);
      model_op(1, 7, 0);
      check_resp();
      release_resp(1);
      bus.vector_in = {2'd1, TW'(7), DW'(0)};
      bus.req_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("en0_req_ready", 32'(bus.req_ready), 32'd0);
         chk("en0_resp_valid", 32'(bus.resp_valid), 32'd0);
      end
      bus.req_valid = 1'b0;
      enable = 1'b1;
      @(negedge clk);

      // Randomized traffic with occasional backpressure.
      for (int n = 0; n < 300; n++) begin
         int r, op, stall;
         r  = int'($urandom_range(0, 99));
         op = (r < 4) ? 0 : (r < 45) ? 1 : (r < 85) ? 2 : 3;
         stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         do_op(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), stall);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_l2_lru.md
# cache_l2_lru

Parametrised, clocked successor to the combinational L2 cache: a fully-associative tag/data store with a valid/ready request and response handshake, true-LRU replacement, an INVALIDATE opcode and eviction reporting. It sits between the L1 caches and the memory/arbiter path. It accepts the same `{opcode, tag, data}` request vector as the current L2. It returns a registered response that carries hit status plus, on a write that displaces a valid line, the evicted tag and data for write-back.

## Interface
- `TAG_WIDTH`, 4: tag bits per line.
- `DATA_WIDTH`, 8: data bits per line.
- `ENTRIES`, 16: number of lines; power of two, at least 2.
- `OPCODE_WIDTH`, 2: opcode field width; fixed at 2.
- `LINE_WIDTH`, `OPCODE_WIDTH+TAG_WIDTH+DATA_WIDTH`: request vector width (derived).
- `ENTRY_BITS`, `$clog2(ENTRIES)`: index and age width (derived).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, `req_ready` is forced low; an in-flight operation still completes.
- `vector_in`  in  LINE_WIDTH  request vector `{opcode[MSBs], tag, data[LSBs]}`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `resp_valid`  out  1  response registers valid.
- `resp_ready`  in  1  consumer takes the response.
- `data_out`  out  DATA_WIDTH  read data; 0 on a miss and for non-READ opcodes.
- `hit_miss_out`  out  1  1 = hit.
- `evict_out`  out  1  1 = a write miss displaced a valid line.
- `evict_tag_out`  out  TAG_WIDTH  tag of the displaced line.
- `evict_data_out`  out  DATA_WIDTH  data of the displaced line.

## Operation
- Opcodes: FLASH 2'b00, READ 2'b01, WRITE 2'b10, INVALIDATE 2'b11.
- FSM states and transitions:
  - IDLE to LOOKUP on `req_valid && req_ready`. `req_ready = enable` in IDLE only.
  - LOOKUP to RESP unconditionally; the array update and the response-register load happen on this edge.
  - RESP to IDLE on `resp_ready`; `resp_valid` is high only in RESP.
- Lookup: a hit requires the tag to match and the valid bit to be set. At most one entry matches; writes never create duplicate tags.
- READ hit: `data_out` = line data, hit = 1, entry touched. READ miss: `data_out` = 0, hit = 0, no allocation, no LRU change.
- WRITE hit: line data overwritten, hit = 1, entry touched.
- WRITE miss: the victim is the lowest-index invalid entry. If every entry is valid, the victim is the entry with age `ENTRIES-1`. If the victim was valid, `evict_out` = 1 and `evict_tag_out`/`evict_data_out` carry its old contents. The new tag and data are installed, the valid bit is set, and the entry is touched. hit = 0.
- INVALIDATE: on a hit, the valid bit is cleared and hit = 1; on a miss, hit = 0. Ages are unchanged in both cases.
- FLASH: all valid bits are cleared in one cycle and hit = 0. Tags, data and ages are untouched.
- LRU ages: one `ENTRY_BITS`-wide age per entry; age 0 is MRU. Touching entry e with age a increments every age below a and sets age[e] to 0. The ages always form a permutation of 0..ENTRIES-1.
- `evict_out`, `evict_tag_out` and `evict_data_out` are 0 on every response except an evicting WRITE.

## Timing
- Reset, asynchronous, active-low:
  - state = IDLE; all valid bits = 0; age[i] = i.
  - All outputs 0, except `req_ready`, which follows `enable`.
  - Tag and data arrays are not reset.
- Latency: a request accepted at edge N raises `resp_valid` after edge N+1. The earliest next acceptance is the edge after the response handshake, so throughput is one request per 3 cycles with `resp_ready` held high.
- Response outputs stay stable while `resp_valid && !resp_ready`.
- `vector_in` is captured at acceptance; later changes to it have no effect.
- Reset asserted during LOOKUP or RESP: the operation is abandoned, no array write occurs, and `resp_valid` drops immediately.
- `enable` falling during LOOKUP or RESP: the operation completes normally; only new acceptance is blocked.

## Structure
- Package `cache_pkg`: opcode constants (`OP_FLASH`, `OP_READ`, `OP_WRITE`, `OP_INVALIDATE`), FSM state enum, valid-bit constants, and the hit/miss constants shared with the L1 cache.
- Sub-module `lru_age_tracker`, parameter ENTRIES:
  - inputs: `touch`, `touch_idx`
  - outputs: `lru_idx` (entry with age ENTRIES-1)
  - contains the age array and its reset.

## Test plan
- Reset, then READ tag 4'h9 -> hit = 0, `data_out` = 0, response after 2 cycles.
- WRITE tag 4'h9 data 8'hB2, then READ tag 4'h9 -> hit = 1, `data_out` = 8'hB2.
- Fill 16 distinct tags (0..15, data = tag), READ tag 0, then WRITE tag 4'hA data 8'h55 -> but tag 4'hA is already resident, so instead first FLASH, refill tags 0..15, READ tag 0, WRITE new tag via TAG_WIDTH=5 build (tag 16) -> `evict_out` = 1, `evict_tag_out` = 1, `evict_data_out` = 1 (tag 1 is LRU).
- INVALIDATE tag 3 after a write, then READ tag 3 -> hit = 0. A following WRITE miss reuses entry 3 with `evict_out` = 0.
- Hold `resp_ready` = 0 for 5 cycles -> `resp_valid` and `data_out` stay stable and `req_ready` = 0. Pulse `reset` low in RESP -> all outputs clear and a later READ misses.
- FLASH after 4 writes -> hit = 0; every subsequent READ misses; `enable` = 0 keeps `req_ready` = 0 while `req_valid` = 1.
